keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart to the calculator's multiplexed seven-segment output path.
- Scans a 4x4 matrix keypad by driving one row low at a time and reading the columns.
- Debounces press and release, then presents a 4-bit key code to the calculator core over a valid/ack handshake.
- Sits between the board keypad pins and the calculator control FSM.

Parameters:
- SCAN_DIV_W, 5: row dwell time is 2^SCAN_DIV_W clk cycles.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a press or a release (minimum 2).
- REPEAT_CYCLES, 1024: hold time before and between auto-repeats. Used only with KEYPAD_AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- col_i  in  4  keypad columns, active-low, externally pulled up, asynchronous to clk
- row_o  out  4  keypad row drive, active-low one-hot
- key_code_o  out  4  code of the last accepted key
- key_valid_o  out  1  key_code_o holds an unconsumed key
- key_ack_i  in  1  consumer acknowledges the key
- key_held_o  out  1  a debounced key is currently held
- overrun_o  out  1  sticky; a key was overwritten before it was acked

Behaviour:
- Reset (async, rst_n=0) forces:
  - row_o=4'b1110 (row 0)
  - key_code_o=0, key_valid_o=0, key_held_o=0, overrun_o=0
  - FSM=SCAN, all counters 0, column synchronizer=4'b1111
- col_i passes through a 2-flop synchronizer. All column logic uses the synchronized value (cs); raw-pin-to-decision latency is 2 cycles.
- Key map, (row,col) -> code:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: *=E, 0=0, #=F, D
  - Digits are BCD-valued.
- SCAN state:
  - Dwell counter increments every cycle.
  - On its terminal count (all ones), cs is sampled. This gives the line 2^SCAN_DIV_W-1 cycles to settle.
  - Exactly one cs bit low: capture row/column, freeze row_o, go to DEB_PRESS.
  - Zero bits low, or two or more bits low (ghosting/multi-key): ignore, advance row_o to the next row (row3 wraps to row0), reset the dwell counter.
- DEB_PRESS state:
  - Counter counts cycles in which cs equals the captured pattern.
  - Any mismatch: back to SCAN on the same row with the dwell counter cleared.
  - Count reaches DEBOUNCE_CYCLES: accept the key (see handshake rules), set key_held_o=1, go to HELD.
- HELD state:
  - row_o stays frozen.
  - cs==4'b1111: go to DEB_REL.
- DEB_REL state:
  - Requires DEBOUNCE_CYCLES consecutive cycles of cs==4'b1111.
  - Any low bit returns to HELD without a second accept.
  - On completion: key_held_o=0, advance to the next row, go to SCAN.
- Handshake:
  - Accept: key_code_o<=code and key_valid_o<=1 on the following clk edge.
  - key_ack_i while key_valid_o=1 clears key_valid_o next cycle.
  - key_ack_i while key_valid_o=0 is ignored.
  - Accept while valid=1 and no ack: code overwritten, valid stays 1, overrun_o<=1.
  - Accept and ack in the same cycle: new key wins, valid stays 1, no overrun.
- overrun_o clears only on reset.
- Press-to-valid latency from a stable col_i edge: at most 2 + 4*2^SCAN_DIV_W + DEBOUNCE_CYCLES + 1 cycles.
- Reset asserted mid-debounce or mid-hold aborts immediately. No key is emitted after release of reset until a full new press is debounced.

Optional Feature:
- KEYPAD_AUTOREPEAT_EN defined:
  - In HELD, a repeat counter runs while the key stays held.
  - Reaching REPEAT_CYCLES re-accepts the same code under the same handshake/overrun rules, then the counter restarts.
  - The counter clears on entry to HELD and on entry to DEB_REL.
- Not defined: exactly one accept per press. The REPEAT_CYCLES parameter is unused and its logic is absent.

Test Plan:
- SCAN_DIV_W=2, DEBOUNCE_CYCLES=4. Idle with col_i=4'b1111 -> row_o cycles 1110, 1101, 1011, 0111, 1110 every 4 cycles; key_valid_o stays 0.
- Press row1/col2 (col_i[2]=0 only while row_o=1101), held 40 cycles -> key_code_o=4'h6, key_valid_o=1 within 23 cycles; key_ack_i pulse -> valid=0 next cycle; exactly one accept.
- Press row3/col1 with 1-cycle glitches during the first 3 debounce cycles -> no accept until 4 clean cycles; final key_code_o=4'h0.
- Accept "7", no ack, then release and press "9" -> key_code_o=4'h9, key_valid_o=1, overrun_o=1; repeat with ack in the accept cycle -> overrun_o stays 0.
- Two columns low on row0 -> no accept, scan continues; rst_n=0 during HELD -> outputs return to reset values immediately, row_o=1110.
- KEYPAD_AUTOREPEAT_EN, REPEAT_CYCLES=50, hold "A", ack every accept -> accepts at debounce completion, then every 50 cycles, all with key_code_o=4'hA.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a valid/ack key handshake.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV_W      = 5,
    parameter int DEBOUNCE_CYCLES = 16
`ifdef KEYPAD_AUTOREPEAT_EN
   ,parameter int REPEAT_CYCLES   = 1024
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_i,
    output logic [3:0] row_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    input  logic       key_ack_i,
    output logic       key_held_o,
    output logic       overrun_o
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t                state, state_n;
    logic [3:0]            col_meta, cs;
    logic [SCAN_DIV_W-1:0] dwell, dwell_n;
    logic [DEB_W-1:0]      deb_cnt, deb_n;
    logic [1:0]            row_idx, row_n;
    logic [3:0]            cap_pat, cap_n;
    logic                  accept, accept_n;
    logic [3:0]            cs_low;
    logic                  single_low;
    logic [3:0]            cur_code;
`ifdef KEYPAD_AUTOREPEAT_EN
    logic [REP_W-1:0]      rep_cnt, rep_n;
`endif

    function automatic logic [3:0] map_key(input logic [1:0] row, input logic [3:0] pat);
        logic [1:0] col;
        logic [3:0] code;
        case (pat)
            4'b1110: col = 2'd0;
            4'b1101: col = 2'd1;
            4'b1011: col = 2'd2;
            default: col = 2'd3;
        endcase
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Exactly one column pulled low; anything else is idle or a ghosting pattern.
    assign cs_low     = ~cs;
    assign single_low = (cs_low != 4'd0) && ((cs_low & (cs_low - 4'd1)) == 4'd0);
    assign cur_code   = map_key(row_idx, cap_pat);

    always_comb begin
        state_n  = state;
        dwell_n  = dwell;
        deb_n    = deb_cnt;
        row_n    = row_idx;
        cap_n    = cap_pat;
        accept_n = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_n    = rep_cnt;
`endif
        case (state)
            SCAN: begin
                dwell_n = dwell + SCAN_DIV_W'(1);
                if (&dwell) begin
                    dwell_n = '0;
                    if (single_low) begin
                        cap_n   = cs;
                        deb_n   = '0;
                        state_n = DEB_PRESS;
                    end else begin
                        row_n = row_idx + 2'd1;
                    end
                end
            end
            DEB_PRESS: begin
                if (cs == cap_pat) begin
                    if (deb_cnt == DEB_LAST) begin
                        accept_n = 1'b1;
                        deb_n    = '0;
                        state_n  = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_n    = '0;
`endif
                    end else begin
                        deb_n = deb_cnt + DEB_W'(1);
                    end
                end else begin
                    deb_n   = '0;
                    dwell_n = '0;
                    state_n = SCAN;
                end
            end
            HELD: begin
                if (cs == 4'hF) begin
                    deb_n   = '0;
                    state_n = DEB_REL;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_n   = '0;
                end else if (rep_cnt == REP_LAST) begin
                    accept_n = 1'b1;
                    rep_n    = '0;
                end else begin
                    rep_n = rep_cnt + REP_W'(1);
`endif
                end
            end
            DEB_REL: begin
                if (cs == 4'hF) begin
                    if (deb_cnt == DEB_LAST) begin
                        deb_n   = '0;
                        dwell_n = '0;
                        row_n   = row_idx + 2'd1;
                        state_n = SCAN;
                    end else begin
                        deb_n = deb_cnt + DEB_W'(1);
                    end
                end else begin
                    // Bounce during release: the key is still down, no second accept.
                    deb_n   = '0;
                    state_n = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_n   = '0;
`endif
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta   <= 4'hF;
            cs         <= 4'hF;
            state      <= SCAN;
            dwell      <= '0;
            deb_cnt    <= '0;
            row_idx    <= 2'd0;
            row_o      <= 4'b1110;
            cap_pat    <= 4'hF;
            accept     <= 1'b0;
            key_held_o <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt    <= '0;
`endif
        end else begin
            col_meta   <= col_i;
            cs         <= col_meta;
            state      <= state_n;
            dwell      <= dwell_n;
            deb_cnt    <= deb_n;
            row_idx    <= row_n;
            row_o      <= ~(4'b0001 << row_n);
            cap_pat    <= cap_n;
            accept     <= accept_n;
            key_held_o <= (state_n == HELD) || (state_n == DEB_REL);
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt    <= rep_n;
`endif
        end
    end

    // A new key always wins over a same-cycle ack; only an unacked overwrite is an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_o  <= 4'h0;
            key_valid_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else if (accept) begin
            key_code_o  <= cur_code;
            key_valid_o <= 1'b1;
            if (key_valid_o && !key_ack_i) begin
                overrun_o <= 1'b1;
            end
        end else if (key_ack_i) begin
            key_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
// Auto-repeat checks are built when KEYPAD_AUTOREPEAT_EN is defined.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] col_i;
    logic [3:0] row_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_ack_i;
    logic       key_held_o;
    logic       overrun_o;

    logic       pressed = 1'b0;
    logic       glitch = 1'b0;
    logic [1:0] key_row = 2'd0;
    logic [3:0] key_pat = 4'hF;
    logic       valid_prev = 1'b0;
    int         accept_cnt = 0;
    int         total = 0;
    int         bad = 0;

    keypad_scanner #(
        .SCAN_DIV_W(2),
        .DEBOUNCE_CYCLES(4)
`ifdef KEYPAD_AUTOREPEAT_EN
       ,.REPEAT_CYCLES(50)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .col_i(col_i),
        .row_o(row_o),
        .key_code_o(key_code_o),
        .key_valid_o(key_valid_o),
        .key_ack_i(key_ack_i),
        .key_held_o(key_held_o),
        .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rowSel(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

    // The pressed key only pulls its columns low while its own row is driven.
    always_comb begin
        col_i = 4'hF;
        if (pressed && !glitch && (row_o == rowSel(key_row))) begin
            col_i = key_pat;
        end
    end

    always @(negedge clk) begin
        if (key_valid_o && !valid_prev) begin
            accept_cnt <= accept_cnt + 1;
        end
        valid_prev <= key_valid_o;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one step after the edge where row_o first drives the key's row.
    task automatic applyStimulus(input logic [1:0] row, input logic [3:0] pat, output int waited);
        int n;
        logic [3:0] target;
        target = rowSel(row);
        pressed = 1'b0;
        n = 0;
        while (row_o == target && n < 40) begin
            tick(1);
            n++;
        end
        key_row = row;
        key_pat = pat;
        pressed = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (row_o != target && n < 40);
        waited = n;
        checkOutput("row_reach", row_o, target);
    endtask

    task automatic releaseKey(input string tag);
        int n;
        pressed = 1'b0;
        n = 0;
        while (key_held_o && n < 20) begin
            tick(1);
            n++;
        end
        checkOutput(tag, key_held_o, 1'b0);
    endtask

    task automatic ackKey(input string tag);
        key_ack_i = 1'b1;
        tick(1);
        key_ack_i = 1'b0;
        checkOutput(tag, key_valid_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        int base;
        rst_n = 1'b0;
        key_ack_i = 1'b0;
        tick(3);
        checkOutput("rst_row", row_o, 4'b1110);
        checkOutput("rst_code", key_code_o, 4'h0);
        checkOutput("rst_valid", key_valid_o, 1'b0);
        checkOutput("rst_held", key_held_o, 1'b0);
        checkOutput("rst_overrun", overrun_o, 1'b0);

        $display("[TB] idle scan");
        rst_n = 1'b1;
        tick(3);
        checkOutput("idle_row0_hold", row_o, 4'b1110);
        tick(1);
        checkOutput("idle_row1", row_o, 4'b1101);
        tick(4);
        checkOutput("idle_row2", row_o, 4'b1011);
        tick(4);
        checkOutput("idle_row3", row_o, 4'b0111);
        tick(4);
        checkOutput("idle_row0_wrap", row_o, 4'b1110);
        checkOutput("idle_valid", key_valid_o, 1'b0);

        $display("[TB] press 6");
        base = accept_cnt;
        applyStimulus(2'd1, 4'b1011, w);
        checkOutput("k6_lat_bound", (w + 9) <= 23, 1'b1);
        tick(8);
        checkOutput("k6_not_early", key_valid_o, 1'b0);
        tick(1);
        checkOutput("k6_valid", key_valid_o, 1'b1);
        checkOutput("k6_code", key_code_o, 4'h6);
        checkOutput("k6_held", key_held_o, 1'b1);
        tick(31);
        ackKey("k6_ack");
        checkOutput("k6_still_held", key_held_o, 1'b1);
        releaseKey("k6_release");
        tick(2);
        checkOutput("k6_one_accept", accept_cnt - base, 1);

        $display("[TB] press 0 with glitches");
        applyStimulus(2'd3, 4'b1101, w);
        for (int k = 0; k < 21; k++) begin
            glitch = (k == 3) || (k == 6) || (k == 9);
            if (k == 20) checkOutput("glitch_no_early", key_valid_o, 1'b0);
            tick(1);
        end
        glitch = 1'b0;
        checkOutput("glitch_valid", key_valid_o, 1'b1);
        checkOutput("glitch_code", key_code_o, 4'h0);
        ackKey("glitch_ack");
        releaseKey("glitch_release");

        $display("[TB] two columns on row 0");
        base = accept_cnt;
        applyStimulus(2'd0, 4'b1100, w);
        tick(4);
        checkOutput("multi_row_adv", row_o, 4'b1101);
        tick(36);
        checkOutput("multi_valid", key_valid_o, 1'b0);
        checkOutput("multi_held", key_held_o, 1'b0);
        checkOutput("multi_no_accept", accept_cnt - base, 0);
        releaseKey("multi_release");

        $display("[TB] overrun 7 then 9");
        applyStimulus(2'd2, 4'b1110, w);
        tick(9);
        checkOutput("ovr_code7", key_code_o, 4'h7);
        checkOutput("ovr_valid7", key_valid_o, 1'b1);
        releaseKey("ovr_release7");
        applyStimulus(2'd2, 4'b1011, w);
        tick(8);
        checkOutput("ovr_before", overrun_o, 1'b0);
        tick(1);
        checkOutput("ovr_code9", key_code_o, 4'h9);
        checkOutput("ovr_valid9", key_valid_o, 1'b1);
        checkOutput("ovr_flag", overrun_o, 1'b1);
        releaseKey("ovr_release9");
        tick(10);
        checkOutput("ovr_sticky", overrun_o, 1'b1);

        $display("[TB] reset during HELD");
        ackKey("hold_pre_ack");
        applyStimulus(2'd1, 4'b1101, w);
        tick(9);
        checkOutput("hold_code5", key_code_o, 4'h5);
        checkOutput("hold_held", key_held_o, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("hrst_row", row_o, 4'b1110);
        checkOutput("hrst_code", key_code_o, 4'h0);
        checkOutput("hrst_valid", key_valid_o, 1'b0);
        checkOutput("hrst_held", key_held_o, 1'b0);
        checkOutput("hrst_overrun", overrun_o, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(12);
        checkOutput("hrst_no_early", key_valid_o, 1'b0);
        tick(1);
        checkOutput("hrst_new_valid", key_valid_o, 1'b1);
        checkOutput("hrst_new_code", key_code_o, 4'h5);
        ackKey("hrst_ack");
        releaseKey("hrst_release");

        $display("[TB] ack in accept cycle");
        applyStimulus(2'd2, 4'b1110, w);
        tick(9);
        checkOutput("sync_code7", key_code_o, 4'h7);
        releaseKey("sync_release7");
        applyStimulus(2'd2, 4'b1011, w);
        tick(8);
        key_ack_i = 1'b1;
        tick(1);
        key_ack_i = 1'b0;
        checkOutput("sync_code9", key_code_o, 4'h9);
        checkOutput("sync_valid9", key_valid_o, 1'b1);
        checkOutput("sync_no_overrun", overrun_o, 1'b0);
        tick(1);
        checkOutput("sync_valid_kept", key_valid_o, 1'b1);
        ackKey("sync_ack");
        releaseKey("sync_release9");

        $display("[TB] hold A");
        base = accept_cnt;
        applyStimulus(2'd0, 4'b0111, w);
        tick(9);
        checkOutput("a_valid", key_valid_o, 1'b1);
        checkOutput("a_code", key_code_o, 4'hA);
        ackKey("a_ack1");
`ifdef KEYPAD_AUTOREPEAT_EN
        tick(48);
        checkOutput("rep1_not_early", key_valid_o, 1'b0);
        tick(1);
        checkOutput("rep1_valid", key_valid_o, 1'b1);
        checkOutput("rep1_code", key_code_o, 4'hA);
        ackKey("rep1_ack");
        tick(48);
        checkOutput("rep2_not_early", key_valid_o, 1'b0);
        tick(1);
        checkOutput("rep2_valid", key_valid_o, 1'b1);
        checkOutput("rep2_code", key_code_o, 4'hA);
        ackKey("rep2_ack");
        releaseKey("a_release");
        checkOutput("rep_accepts", accept_cnt - base, 3);
        checkOutput("rep_no_overrun", overrun_o, 1'b0);
`else
        tick(108);
        checkOutput("a_no_repeat", key_valid_o, 1'b0);
        checkOutput("a_still_held", key_held_o, 1'b1);
        releaseKey("a_release");
        checkOutput("a_one_accept", accept_cnt - base, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
